vec_lsu_seq: RTL and testbench
==============================

# vec_lsu_seq

Strided vector load/store sequencer sitting between the vector issue logic and the vector memory (`bram`: combinational read ports, synchronous write port). It accepts one vector memory request at a time and handles it element by element, for `vl` elements at address `base + i*stride`:

- **Load:** drives one memory read port and streams elements out on a valid/ready interface towards the vector lane.
- **Store:** accepts elements on a valid/ready interface and drives the memory write port.

## Interface

Parameters:
- `WIDTH`, 32: element width in bits; matches memory word width.
- `DEPTH`, 10: memory address width in bits.
- `VL_W`, 7: width of vector-length field; maximum `vl` is 2**`VL_W`-1.

Ports (direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_base` in DEPTH: first element address.
- `req_stride` in DEPTH: two's-complement element stride.
- `req_vl` in VL_W: element count.
- `mem_addr_read` out DEPTH: to one memory read port.
- `mem_rd` in WIDTH: combinational read data for `mem_addr_read`.
- `mem_addr_write` out DEPTH: memory write address.
- `mem_wdata` out WIDTH: memory write data.
- `mem_w_en` out 1: memory write enable.
- `ld_valid` out 1: load element valid.
- `ld_ready` in 1: load element accepted.
- `ld_data` out WIDTH: load element.
- `ld_last` out 1: qualifies final load element.
- `st_valid` in 1: store element present.
- `st_ready` out 1: store element accepted.
- `st_data` in WIDTH: store element.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse when a request completes.
- `stat_ld_cnt`, `stat_st_cnt`, `stat_stall` out 16 each: statistics (see Configuration).

## Operation

- **State machine:** IDLE, LOAD, DRAIN, STORE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch `base`, `stride`, `vl` and set `cur_addr`=`base`, `cnt`=0.
  - If `vl`=0: stay IDLE and pulse `done` next cycle; no memory access.
  - Otherwise go to STORE if `req_store`, else LOAD.
- **LOAD:**
  - `mem_addr_read`=`cur_addr`.
  - One-entry output register (`ld_valid`, `ld_data`, `ld_last`) captures `mem_rd` when it is empty or being drained (`ld_valid`&`ld_ready`). Capturing advances `cur_addr += stride` and `cnt += 1`.
  - `ld_last` is set on the capture where `cnt`=`vl`-1; same edge goes to DRAIN.
- **DRAIN:** when `ld_valid`&`ld_ready`&`ld_last`, go to IDLE with a `done` pulse on the following cycle.
- **STORE:**
  - `st_ready`=1.
  - `mem_w_en` = `st_valid`&`st_ready` (combinational), with `mem_addr_write`=`cur_addr` and `mem_wdata`=`st_data`.
  - Each write advances `cur_addr` and `cnt`; the write where `cnt`=`vl`-1 goes to IDLE and pulses `done` next cycle.
- **Address arithmetic:** `DEPTH` bits, wraps modulo 2**`DEPTH`.
  - Negative stride is legal.
  - Stride 0 repeatedly accesses `base`.
- **Port behaviour outside the active state:**
  - `mem_addr_read` holds its last value outside LOAD.
  - `mem_w_en`=0 and `st_ready`=0 outside STORE.
- **Requests while busy:** never accepted (`req_ready`=0); request fields are ignored.

## Timing

- **Reset values:**
  - State=IDLE.
  - `ld_valid`, `ld_last`, `done`, `mem_w_en`, `busy`, `st_ready`=0.
  - `ld_data`, `mem_addr_read`, `mem_addr_write`, statistics=0.
- **Load latency:**
  - Request accepted at edge E0; `ld_valid`=1 after edge E1.
  - With `ld_ready` held high, one element per cycle; `done` asserts one cycle after the last handshake.
- **Load back-pressure:** `ld_ready`=0 holds `ld_data` stable, with no address advance and no element lost.
- **Store timing:**
  - Memory write commits at the same edge as the `st_valid`&`st_ready` handshake.
  - Throughput one element per cycle.
- **Reset mid-operation:** `rst` aborts immediately. Outputs take reset values next cycle; partial stores already written remain in memory.
- **`done` timing:** `done` never coincides with `req_ready` of the same request. A new request may be accepted in the cycle `done` is high.

## Configuration

- **`VEC_LSU_STATS_EN` defined:**
  - `stat_ld_cnt` counts load handshakes.
  - `stat_st_cnt` counts store writes.
  - `stat_stall` counts cycles with `ld_valid`&!`ld_ready` in LOAD/DRAIN, or !`st_valid` in STORE.
  - All three are 16-bit saturating counters, cleared by `rst`.
- **`VEC_LSU_STATS_EN` undefined:** counters are not built; the three ports are tied to 0.

## Test plan

- **Load, stride 2:** memory holds 0x40000000, 0x40800000, 0x40C00000, 0x41000000 at addresses 64, 66, 68, 70. Load `base`=64, `stride`=2, `vl`=4, `ld_ready`=1 → `ld_data` sequence 0x40000000, 0x40800000, 0x40C00000, 0x41000000 on consecutive cycles; `ld_last` on the 4th; `done` one cycle later.
- **Load back-pressure:** same load with `ld_ready` toggling 1,0,0,1,… → identical data sequence; `ld_data` stable while stalled; no duplicates.
- **Store, negative stride with wrap:** `base`=1, `stride`=-1 (0x3FF), `vl`=3, data 0xA, 0xB, 0xC → memory[1]=0xA, memory[0]=0xB, memory[1023]=0xC; `mem_w_en` exactly 3 cycles.
- **Zero length:** `vl`=0 load → no `ld_valid`, `mem_w_en` stays 0, `done` pulses one cycle after acceptance.
- **Busy and reset:**
  - `req_valid` during an active load → not accepted (`req_ready`=0).
  - `rst` asserted after 2 of 5 store elements → memory holds 2 writes, state IDLE, all outputs at reset values.
- **Statistics (with `VEC_LSU_STATS_EN`):** the back-pressure test yields `stat_ld_cnt`=4 and `stat_stall` = number of stalled cycles. Without the macro, all statistics read 0.

Source files
------------

// File: rtl/vec_lsu_seq.sv
// vec_lsu_seq: strided vector load/store sequencer; define VEC_LSU_STATS_EN to build the statistics counters
module vec_lsu_seq #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int VL_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [DEPTH-1:0] req_base,
  input  logic [DEPTH-1:0] req_stride,
  input  logic [VL_W-1:0]  req_vl,
  output logic [DEPTH-1:0] mem_addr_read,
  input  logic [WIDTH-1:0] mem_rd,
  output logic [DEPTH-1:0] mem_addr_write,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_w_en,
  output logic             ld_valid,
  input  logic             ld_ready,
  output logic [WIDTH-1:0] ld_data,
  output logic             ld_last,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [WIDTH-1:0] st_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stat_ld_cnt,
  output logic [15:0]      stat_st_cnt,
  output logic [15:0]      stat_stall
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, STORE} state_t;
  state_t           r_state;
  logic [DEPTH-1:0] r_cur_addr, r_stride, r_rd_hold;
  logic [VL_W-1:0]  r_vl, r_cnt;
  logic [WIDTH-1:0] r_ld_data;
  logic             r_ld_valid, r_ld_last, r_done;
  logic             w_cap, w_wr, w_last, w_ld_hs;
  assign w_ld_hs        = r_ld_valid & ld_ready;
  assign w_cap          = (r_state == LOAD) & (~r_ld_valid | ld_ready);
  assign w_wr           = (r_state == STORE) & st_valid;
  assign w_last         = (r_cnt + VL_W'(1)) == r_vl;
  assign req_ready      = r_state == IDLE;
  assign busy           = r_state != IDLE;
  assign st_ready       = r_state == STORE;
  assign mem_w_en       = w_wr;
  assign mem_addr_write = r_cur_addr;
  assign mem_wdata      = st_data;
  assign mem_addr_read  = (r_state == LOAD) ? r_cur_addr : r_rd_hold;
  assign ld_valid       = r_ld_valid;
  assign ld_data        = r_ld_data;
  assign ld_last        = r_ld_last;
  assign done           = r_done;
  // sequencer: request capture, element stepping and the one-entry load output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
      r_stride   <= '0;
      r_rd_hold  <= '0;
      r_vl       <= '0;
      r_cnt      <= '0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_ld_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == LOAD) r_rd_hold <= r_cur_addr;
      if (w_cap | w_wr) begin
        r_cur_addr <= r_cur_addr + r_stride;
        r_cnt      <= r_cnt + VL_W'(1);
      end
      if (w_cap) begin
        r_ld_valid <= 1'b1;
        r_ld_data  <= mem_rd;
        r_ld_last  <= w_last;
      end else if (w_ld_hs) begin
        r_ld_valid <= 1'b0;
        r_ld_last  <= 1'b0;
      end
      case (r_state)
        IDLE: if (req_valid) begin
          r_cur_addr <= req_base;
          r_stride   <= req_stride;
          r_vl       <= req_vl;
          r_cnt      <= '0;
          if (req_vl == '0) r_done <= 1'b1;
          else r_state <= req_store ? STORE : LOAD;
        end
        LOAD: if (w_cap & w_last) r_state <= DRAIN;
        DRAIN: if (w_ld_hs & r_ld_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        STORE: if (w_wr & w_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      endcase
    end
  end
`ifdef VEC_LSU_STATS_EN
  logic [15:0] r_ld_cnt, r_st_cnt, r_stall;
  logic        w_stall;
  assign w_stall = ((r_state == LOAD || r_state == DRAIN) & r_ld_valid & ~ld_ready) | ((r_state == STORE) & ~st_valid);
  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
      r_stall  <= '0;
    end else begin
      if (w_ld_hs && ~&r_ld_cnt) r_ld_cnt <= r_ld_cnt + 16'd1;
      if (w_wr && ~&r_st_cnt) r_st_cnt <= r_st_cnt + 16'd1;
      if (w_stall && ~&r_stall) r_stall <= r_stall + 16'd1;
    end
  end
  assign stat_ld_cnt = r_ld_cnt;
  assign stat_st_cnt = r_st_cnt;
  assign stat_stall  = r_stall;
`else
  assign stat_ld_cnt = '0;
  assign stat_st_cnt = '0;
  assign stat_stall  = '0;
`endif
endmodule

// File: tb/tb_vec_lsu_seq.sv
// tb_vec_lsu_seq: randomized self-checking bench for vec_lsu_seq against a memory/element-list reference model
module tb_vec_lsu_seq;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [9:0]  req_base = '0, req_stride = '0;
  logic [6:0]  req_vl = '0;
  logic        ld_ready = 1'b0, st_valid = 1'b0;
  logic [31:0] st_data = '0;
  logic        req_ready, mem_w_en, ld_valid, ld_last, st_ready, busy, done;
  logic [9:0]  mem_addr_read, mem_addr_write;
  logic [31:0] mem_rd, mem_wdata, ld_data;
  logic [15:0] stat_ld_cnt, stat_st_cnt, stat_stall;
  logic [31:0] mem [1024];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_a = '0;
  logic [31:0] tb_d = '0;
  logic [31:0] st_q [$];
  int          checks = 0, errors = 0, wcnt = 0;

  always #5 clk = ~clk;

  vec_lsu_seq #(.WIDTH(32), .DEPTH(10), .VL_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl),
    .mem_addr_read(mem_addr_read), .mem_rd(mem_rd), .mem_addr_write(mem_addr_write),
    .mem_wdata(mem_wdata), .mem_w_en(mem_w_en), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .busy(busy), .done(done), .stat_ld_cnt(stat_ld_cnt), .stat_st_cnt(stat_st_cnt), .stat_stall(stat_stall)
  );

  assign mem_rd = mem[mem_addr_read];

  always @(posedge clk) begin
    if (mem_w_en) begin
      mem[mem_addr_write] <= mem_wdata;
      wcnt <= wcnt + 1;
    end else if (tb_we) mem[tb_a] <= tb_d;
  end

  task automatic test_reset;
    @(negedge clk);
    req_valid = 0; st_valid = 0; ld_ready = 0; tb_we = 0; rst = 1;
    @(negedge clk);
    checks++;
    if ({ld_valid, ld_last, done, mem_w_en, busy, st_ready, req_ready} !== 7'b0000001 || ld_data !== 0 ||
        mem_addr_read !== 0 || mem_addr_write !== 0 || stat_ld_cnt !== 0 || stat_st_cnt !== 0 || stat_stall !== 0) begin
      errors++;
      $display("FAIL reset: ctl=%b ld_data=%h rd=%h wr=%h stats=%0d/%0d/%0d, want ctl=0000001 and all zero",
               {ld_valid, ld_last, done, mem_w_en, busy, st_ready, req_ready}, ld_data, mem_addr_read,
               mem_addr_write, stat_ld_cnt, stat_st_cnt, stat_stall);
    end
    rst = 0;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 1024; i++) begin
      tb_a = 10'(i); tb_d = $urandom; tb_we = 1;
      @(negedge clk);
    end
    tb_we = 0;
  endtask

  task automatic poke_mem(input logic [9:0] a, input logic [31:0] d);
    tb_a = a; tb_d = d; tb_we = 1;
    @(negedge clk);
    tb_we = 0;
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic do_load(input logic [9:0] b, input logic [9:0] s, input logic [6:0] n, input int mode,
                         input bit poke, output int stalls);
    logic [31:0] exp [$];
    logic [31:0] prev_data;
    bit          prev_stall;
    int          idx, cyc, w0;
    stalls = 0;
    for (int i = 0; i < int'(n); i++) exp.push_back(mem[10'(b + i * s)]);
    w0 = wcnt;
    @(negedge clk);
    req_valid = 1; req_store = 0; req_base = b; req_stride = s; req_vl = n;
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL load_accept: req_ready=%b want 1", req_ready); end
    @(negedge clk);
    if (poke) begin req_store = 1; req_vl = 7'd3; req_base = ~b; end
    else req_valid = 0;
    ld_ready = (mode == 2) ? 1'($urandom) : 1'b1;
    checks++;
    if (ld_valid !== 0 || busy !== 1) begin errors++; $display("FAIL load_latency: ld_valid=%b busy=%b want 0 1", ld_valid, busy); end
    idx = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    while (idx < int'(n) && cyc < 2000) begin
      @(negedge clk);
      ld_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 3 == 0) : 1'($urandom);
      if (poke && cyc < 3) begin
        checks++;
        if (req_ready !== 0 || busy !== 1) begin errors++; $display("FAIL busy_reject: req_ready=%b busy=%b want 0 1", req_ready, busy); end
      end
      if (poke && cyc == 3) req_valid = 0;
      if (mode == 0) begin
        checks++;
        if (ld_valid !== 1) begin errors++; $display("FAIL load_stream: ld_valid=%b at element %0d want 1", ld_valid, idx); end
      end
      if (ld_valid) begin
        checks++;
        if (ld_data !== exp[idx] || ld_last !== (idx == int'(n) - 1)) begin
          errors++;
          $display("FAIL load_data[%0d]: data=%h last=%b want %h %b", idx, ld_data, ld_last, exp[idx], idx == int'(n) - 1);
        end
        if (prev_stall) begin
          checks++;
          if (ld_data !== prev_data) begin errors++; $display("FAIL load_stable: data=%h want %h", ld_data, prev_data); end
        end
        if (ld_ready) idx++;
        else stalls++;
      end
      prev_stall = ld_valid && !ld_ready;
      prev_data = ld_data;
      cyc++;
    end
    if (idx < int'(n)) begin errors++; $display("FAIL load_timeout: got %0d of %0d elements", idx, n); end
    @(negedge clk);
    ld_ready = 0; req_valid = 0;
    checks++;
    if (done !== 1 || busy !== 0 || ld_valid !== 0 || wcnt !== w0) begin
      errors++;
      $display("FAIL load_done: done=%b busy=%b ld_valid=%b writes=%0d want 1 0 0 0", done, busy, ld_valid, wcnt - w0);
    end
    @(negedge clk);
    checks++;
    if (done !== 0) begin errors++; $display("FAIL done_pulse: done=%b want 0", done); end
  endtask

  // mode 0: valid always, 1: random valid; lim < n resets after lim writes
  task automatic do_store(input logic [9:0] b, input logic [9:0] s, input logic [6:0] n, input int mode,
                          input int lim, output int stalls);
    logic [31:0] e [1024];
    int idx, cyc, w0, bad;
    stalls = 0;
    for (int i = 0; i < 1024; i++) e[i] = mem[i];
    for (int i = 0; i < lim; i++) e[10'(b + i * s)] = st_q[i];
    w0 = wcnt;
    @(negedge clk);
    req_valid = 1; req_store = 1; req_base = b; req_stride = s; req_vl = n;
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL store_accept: req_ready=%b want 1", req_ready); end
    @(negedge clk);
    req_valid = 0;
    idx = 0; cyc = 0;
    while (idx < lim && cyc < 2000) begin
      st_valid = (mode == 0) ? 1'b1 : 1'($urandom);
      st_data = st_q[idx];
      checks++;
      if (st_ready !== 1 || busy !== 1) begin errors++; $display("FAIL store_ready: st_ready=%b busy=%b want 1 1", st_ready, busy); end
      if (st_valid) idx++;
      else stalls++;
      cyc++;
      @(negedge clk);
    end
    st_valid = 0;
    if (idx < lim) begin errors++; $display("FAIL store_timeout: wrote %0d of %0d", idx, lim); end
    if (lim < int'(n)) test_reset;
    else begin
      checks++;
      if (done !== 1 || busy !== 0 || st_ready !== 0) begin
        errors++;
        $display("FAIL store_done: done=%b busy=%b st_ready=%b want 1 0 0", done, busy, st_ready);
      end
    end
    checks++;
    if (wcnt - w0 !== lim) begin errors++; $display("FAIL store_wen_count: %0d want %0d", wcnt - w0, lim); end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== e[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL store_mem: %0d words differ from expected, want 0", bad); end
  endtask

  task automatic test_load_stride2;
    int st;
    poke_mem(10'd64, 32'h40000000); poke_mem(10'd66, 32'h40800000);
    poke_mem(10'd68, 32'h40C00000); poke_mem(10'd70, 32'h41000000);
    do_load(10'd64, 10'd2, 7'd4, 0, 0, st);
  endtask

  task automatic test_backpressure;
    int st;
    do_load(10'd64, 10'd2, 7'd4, 1, 0, st);
  endtask

  task automatic test_store_wrap;
    int st;
    st_q = '{32'hA, 32'hB, 32'hC};
    do_store(10'd1, 10'h3FF, 7'd3, 0, 3, st);
    checks++;
    if (mem[1] !== 32'hA || mem[0] !== 32'hB || mem[1023] !== 32'hC) begin
      errors++;
      $display("FAIL store_wrap: m1=%h m0=%h m1023=%h want a b c", mem[1], mem[0], mem[1023]);
    end
  endtask

  task automatic test_zero_len;
    int w0 = wcnt;
    @(negedge clk);
    req_valid = 1; req_store = 0; req_base = 10'd5; req_stride = 10'd1; req_vl = 0;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (done !== 1 || busy !== 0 || ld_valid !== 0 || req_ready !== 1) begin
      errors++;
      $display("FAIL zero_len: done=%b busy=%b ld_valid=%b req_ready=%b want 1 0 0 1", done, busy, ld_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 0 || ld_valid !== 0 || wcnt !== w0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b ld_valid=%b writes=%0d want 0 0 0", done, ld_valid, wcnt - w0);
    end
  endtask

  task automatic test_busy;
    int st;
    do_load(10'd100, 10'd7, 7'd6, 0, 1, st);
  endtask

  task automatic test_reset_mid;
    int st;
    st_q.delete();
    for (int i = 0; i < 5; i++) st_q.push_back($urandom);
    do_store(10'd200, 10'd3, 7'd5, 0, 2, st);
  endtask

  task automatic test_random;
    int st;
    for (int k = 0; k < 8; k++) do_load(10'($urandom), 10'($urandom), 7'($urandom_range(1, 20)), 2, 0, st);
    for (int k = 0; k < 8; k++) begin
      st_q.delete();
      for (int i = 0; i < 20; i++) st_q.push_back($urandom);
      do_store(10'($urandom), (k == 0) ? 10'd0 : 10'($urandom), 7'($urandom_range(1, 20)), 1, 0, st);
    end
  endtask

  task automatic test_random_store_full;
    int st, n;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 20);
      st_q.delete();
      for (int i = 0; i < n; i++) st_q.push_back($urandom);
      do_store(10'($urandom), (k == 0) ? 10'd0 : 10'($urandom), 7'(n), 1, n, st);
    end
  endtask

  task automatic test_stats;
    int ls, ss;
    int el, es, ev;
    test_reset;
    do_load(10'd64, 10'd2, 7'd4, 1, 0, ls);
    st_q.delete();
    for (int i = 0; i < 3; i++) st_q.push_back($urandom);
    do_store(10'd300, 10'd1, 7'd3, 1, 3, ss);
`ifdef VEC_LSU_STATS_EN
    el = 4; es = 3; ev = ls + ss;
`else
    el = 0; es = 0; ev = 0;
`endif
    checks++;
    if (stat_ld_cnt !== 16'(el) || stat_st_cnt !== 16'(es) || stat_stall !== 16'(ev)) begin
      errors++;
      $display("FAIL stats: ld=%0d st=%0d stall=%0d want %0d %0d %0d", stat_ld_cnt, stat_st_cnt, stat_stall, el, es, ev);
    end
  endtask

  initial begin
    test_reset;
    fill_mem;
    test_load_stride2;
    test_backpressure;
    test_store_wrap;
    test_zero_len;
    test_busy;
    test_reset_mid;
    test_random_store_full;
    test_random;
    test_stats;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
